// File: rtl/dither_reconstruct_if.sv
// Pixel stream bundle between the dithered 4-bit RGB source and the
// 8-bit reconstruction filter.
interface dither_reconstruct_if;
  logic        visible;
  logic [11:0] din;
  logic [23:0] dout;
  logic        dout_valid;
  logic        dout_visible;

  modport master (
    output visible, din,
    input  dout, dout_valid, dout_visible
  );

  modport slave (
    input  visible, din,
    output dout, dout_valid, dout_visible
  );
endinterface

// File: rtl/dither_reconstruct.sv
// Rebuilds an 8-bit-per-channel RGB estimate from a 4-bit dithered stream
// using a per-line sliding box filter over the last 2^WINDOW_LOG2 pixels.
// Blanking (visible=0) or rst wipes the window so no average spans lines.
module dither_reconstruct #(
  parameter int WINDOW_LOG2 = 4
) (
  input logic             clk,
  input logic             rst,
  dither_reconstruct_if.slave bus
);

  localparam int N      = 1 << WINDOW_LOG2;
  localparam int SUM_W  = 4 + WINDOW_LOG2;
  localparam int FILL_W = WINDOW_LOG2 + 1;
  localparam logic [FILL_W-1:0] N_F = FILL_W'(N);

  // Window sum scaled back to 8 bits; 15*N lands on 0xF0, so it cannot wrap.
  function automatic logic [7:0] scale(input logic [SUM_W-1:0] sum);
    logic [7:0] w;
    w = 8'(sum);
    return w << (4 - WINDOW_LOG2);
  endfunction

  // Stage p0: window state and registered outputs
  logic [FILL_W-1:0] fill_p0;
  logic [SUM_W-1:0]  sum_p0  [3];
  logic [3:0]        hist_p0 [3][N];
  logic [23:0]       dout_p0;
  logic              vld_p0;
  logic              vis_p0;

  logic              run;
  logic              full_nx;
  logic [FILL_W-1:0] fill_nx;
  logic [3:0]        s_ch    [3];
  logic [SUM_W:0]    wide    [3];
  logic [SUM_W-1:0]  sum_nx  [3];
  logic [7:0]        ch_out  [3];

  // Next sum per channel: add the new nibble, drop the oldest once the window is full.
  always_comb begin
    run     = (fill_p0 == N_F);
    fill_nx = run ? fill_p0 : fill_p0 + 1'b1;
    full_nx = (fill_nx == N_F);
    for (int c = 0; c < 3; c++) begin
      s_ch[c]   = bus.din[c*4 +: 4];
      wide[c]   = {1'b0, sum_p0[c]} + (SUM_W+1)'(s_ch[c])
                  - (run ? (SUM_W+1)'(hist_p0[c][N-1]) : '0);
      sum_nx[c] = wide[c][SUM_W-1:0];
      ch_out[c] = full_nx ? scale(sum_nx[c]) : {s_ch[c], 4'h0};
    end
  end

  // Window update; blanking and reset both restart the line from empty.
  always_ff @(posedge clk) begin
    if (rst || !bus.visible) begin
      fill_p0 <= '0;
      dout_p0 <= '0;
      vld_p0  <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        sum_p0[c] <= '0;
        for (int i = 0; i < N; i++) hist_p0[c][i] <= '0;
      end
    end else begin
      fill_p0 <= fill_nx;
      dout_p0 <= {ch_out[2], ch_out[1], ch_out[0]};
      vld_p0  <= full_nx;
      for (int c = 0; c < 3; c++) begin
        sum_p0[c]     <= sum_nx[c];
        hist_p0[c][0] <= s_ch[c];
        for (int i = 1; i < N; i++) hist_p0[c][i] <= hist_p0[c][i-1];
      end
    end
  end

  // Active-video qualifier delayed to line up with dout.
  always_ff @(posedge clk) begin
    vis_p0 <= bus.visible & ~rst;
  end

  assign bus.dout         = dout_p0;
  assign bus.dout_valid   = vld_p0;
  assign bus.dout_visible = vis_p0;

endmodule

// File: doc/dither_reconstruct.md
# dither_reconstruct

Receive-side counterpart of the 8-to-4-bit error-diffusion ditherer in the VGA serial display path. Takes the dithered 4-bit-per-channel RGB pixel stream and rebuilds an 8-bit-per-channel estimate with a per-line sliding box filter over the last 2^WINDOW_LOG2 visible pixels.
- Used in the verification harness to check that dithered output preserves the mean input color.
- Used on the readback/capture path, where 8-bit values are needed.

## Interface
- WINDOW_LOG2, default 4: log2 of window length N; legal range 1..4 (N = 2..16).
- clk  in  1  pixel clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- visible  in  1  pixel valid / active-video qualifier; low during blanking.
- din  in  12  dithered pixel: [11:8] R nibble, [7:4] G nibble, [3:0] B nibble.
- dout  out  24  reconstructed pixel: [23:16] R, [15:8] G, [7:0] B.
- dout_valid  out  1  window full; dout is a true N-sample average.
- dout_visible  out  1  visible delayed by one cycle, aligned with dout.

## Operation
- Three identical, independent channel datapaths:
  - N-entry by 4-bit shift register (sample history).
  - Running sum, 4+WINDOW_LOG2 bits wide.
- Shared fill counter, 0..N, saturating at N.
- Modes:
  - CLEAR: visible=0.
  - FILL: visible=1, fill < N.
  - RUN: visible=1, fill = N.
- On a cycle with visible=1, per channel, with s = incoming nibble:
  - FILL: sum_next = sum + s; fill_next = fill + 1.
  - RUN: sum_next = sum + s - oldest; oldest is the entry shifted out this cycle. Subtraction never underflows, because oldest is already contained in sum.
  - Shift s into history.
- Registered output, from sum_next (window includes the current sample):
  - RUN, or FILL reaching fill_next = N: channel out = sum_next << (4 - WINDOW_LOG2); dout_valid = 1.
  - FILL with fill_next < N: channel out = {s, 4'h0} (passthrough); dout_valid = 0.
- Output range: maximum sum 15·N scales to 0xF0. Output never exceeds 0xF0 and never wraps.
- On a cycle with visible=0, all state clears in one cycle:
  - Sums, history and fill counter go to 0.
  - Next cycle: dout = 0, dout_valid = 0.
  - Each visible run (scan line) therefore starts a fresh window. No error or averaging crosses blanking, matching the ditherer's error clear on blanking.
- Reset: same clear as visible=0, and dout_visible = 0. rst has priority over visible.

## Timing
- Latency: 1 clk from din/visible to dout/dout_valid/dout_visible.
- Reset values: dout = 0, dout_valid = 0, dout_visible = 0; all internal state 0.
- First dout_valid = 1 appears N cycles after the rising edge of visible: the cycle after the N-th visible sample.
- dout_valid falls the cycle after visible falls.
- A visible pulse shorter than N cycles never raises dout_valid.
- rst asserted mid-line: the next cycle shows reset values. After rst releases with visible=1, FILL restarts from fill = 0.
- One visible=0 cycle between visible=1 cycles is enough to fully restart the window.
- No backpressure. A new sample is accepted every visible cycle.

## Test plan
- Constant din = 12'h888, visible=1 for 20 cycles (N=16):
  - Cycles 1..15 after the edge: dout = 24'h808080, dout_valid = 0.
  - Cycle 16 onward: dout = 24'h808080, dout_valid = 1.
- R nibble alternating 7,8 for 16+ cycles, G/B = 0:
  - Once valid, R out = 0x78 (sum 120), steady every cycle after the window is full.
- R stream of 12×0xA and 4×0x9 in any order: R out = 0x9C once valid, then tracks the sliding sum exactly (scoreboard vs. reference model). All-0xF input gives 0xF0 with no wrap.
- Blanking mid-window: drop visible after 10 samples.
  - Next cycle: dout = 0, dout_valid = 0, dout_visible = 0.
  - Resume: 16 new cycles are needed before valid. The first output equals the new samples only.
- Assert rst for 1 cycle at sample 20 of a valid run:
  - All outputs read 0 the next cycle.
  - FILL restarts on release. The 16th post-reset sample raises dout_valid.
- WINDOW_LOG2=2, R = 3,3,3,3: fourth sample gives R out = 0x30 and dout_valid = 1. Fifth sample = 7 gives R out = (3+3+3+7)<<2 = 0x40.
